// File: rtl/int_issue_queue_if.sv
// Bundle of dispatch, wakeup, redirect and issue signals for the integer issue queue.
// The slave side is the queue; the master side is its environment.
interface int_issue_queue_if #(
  parameter int DEPTH   = 8,
  parameter int PREG_W  = 6,
  parameter int ROB_LOG = 6,
  parameter int UOP_W   = 96
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               enq_valid;
  logic               enq_ready;
  logic [PREG_W-1:0]  enq_prd;
  logic [PREG_W-1:0]  enq_prs1;
  logic [PREG_W-1:0]  enq_prs2;
  logic               enq_src1_rdy;
  logic               enq_src2_rdy;
  logic               enq_robidx_flag;
  logic [ROB_LOG-1:0] enq_robidx;
  logic [UOP_W-1:0]   enq_uop;

  logic               wb_valid;
  logic [PREG_W-1:0]  wb_prd;

  logic               flush_valid;
  logic               flush_robidx_flag;
  logic [ROB_LOG-1:0] flush_robidx;

  logic               iss_valid;
  logic               iss_ready;
  logic [PREG_W-1:0]  iss_prd;
  logic [PREG_W-1:0]  iss_prs1;
  logic [PREG_W-1:0]  iss_prs2;
  logic               iss_robidx_flag;
  logic [ROB_LOG-1:0] iss_robidx;
  logic [UOP_W-1:0]   iss_uop;

  logic [CNT_W-1:0]   count;

  modport slave (
    input  enq_valid, enq_prd, enq_prs1, enq_prs2, enq_src1_rdy, enq_src2_rdy,
           enq_robidx_flag, enq_robidx, enq_uop,
           wb_valid, wb_prd,
           flush_valid, flush_robidx_flag, flush_robidx,
           iss_ready,
    output enq_ready, iss_valid, iss_prd, iss_prs1, iss_prs2,
           iss_robidx_flag, iss_robidx, iss_uop, count
  );

  modport master (
    output enq_valid, enq_prd, enq_prs1, enq_prs2, enq_src1_rdy, enq_src2_rdy,
           enq_robidx_flag, enq_robidx, enq_uop,
           wb_valid, wb_prd,
           flush_valid, flush_robidx_flag, flush_robidx,
           iss_ready,
    input  enq_ready, iss_valid, iss_prd, iss_prs1, iss_prs2,
           iss_robidx_flag, iss_robidx, iss_uop, count
  );
endinterface

// File: rtl/int_issue_queue.sv
// Integer out-of-order issue queue: holds renamed uops, wakes sources on writeback,
// issues the oldest ready entry by ROB age and squashes younger entries on redirect.
module int_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int PREG_W  = 6,
  parameter int ROB_LOG = 6,
  parameter int UOP_W   = 96
) (
  input  logic            clock,
  input  logic            reset_n,
  int_issue_queue_if.slave io
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Control state (reset)
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d;
  logic [DEPTH-1:0] rdy2_q, rdy2_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Payload state (not reset; only meaningful while valid)
  logic [PREG_W-1:0]  prd_q   [DEPTH];
  logic [PREG_W-1:0]  prd_d   [DEPTH];
  logic [PREG_W-1:0]  prs1_q  [DEPTH];
  logic [PREG_W-1:0]  prs1_d  [DEPTH];
  logic [PREG_W-1:0]  prs2_q  [DEPTH];
  logic [PREG_W-1:0]  prs2_d  [DEPTH];
  logic               flag_q  [DEPTH];
  logic               flag_d  [DEPTH];
  logic [ROB_LOG-1:0] robidx_q[DEPTH];
  logic [ROB_LOG-1:0] robidx_d[DEPTH];
  logic [UOP_W-1:0]   uop_q   [DEPTH];
  logic [UOP_W-1:0]   uop_d   [DEPTH];

  logic [DEPTH-1:0] cand;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             enq_fire;
  logic             iss_fire;

  // A is older than B; the wrap flag flips the index comparison.
  function automatic logic older(input logic af, input logic [ROB_LOG-1:0] ai,
                                 input logic bf, input logic [ROB_LOG-1:0] bi);
    return (af == bf) ? (ai < bi) : (ai > bi);
  endfunction

  always_comb begin
    cand      = valid_q & rdy1_q & rdy2_q;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand[i] && (!win_found ||
          older(flag_q[i], robidx_q[i], flag_q[win_idx], robidx_q[win_idx]))) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign io.enq_ready = (count_q < CNT_W'(DEPTH)) & ~io.flush_valid;
  assign io.iss_valid = win_found & ~io.flush_valid;
  assign enq_fire     = io.enq_valid & io.enq_ready & free_found;
  assign iss_fire     = io.iss_valid & io.iss_ready;

  assign io.iss_prd         = io.iss_valid ? prd_q[win_idx]    : '0;
  assign io.iss_prs1        = io.iss_valid ? prs1_q[win_idx]   : '0;
  assign io.iss_prs2        = io.iss_valid ? prs2_q[win_idx]   : '0;
  assign io.iss_robidx_flag = io.iss_valid ? flag_q[win_idx]   : 1'b0;
  assign io.iss_robidx      = io.iss_valid ? robidx_q[win_idx] : '0;
  assign io.iss_uop         = io.iss_valid ? uop_q[win_idx]    : '0;
  assign io.count           = count_q;

  always_comb begin
    valid_d  = valid_q;
    rdy1_d   = rdy1_q;
    rdy2_d   = rdy2_q;
    prd_d    = prd_q;
    prs1_d   = prs1_q;
    prs2_d   = prs2_q;
    flag_d   = flag_q;
    robidx_d = robidx_q;
    uop_d    = uop_q;
    count_d  = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && io.wb_valid && io.wb_prd == prs1_q[i]) rdy1_d[i] = 1'b1;
      if (valid_q[i] && io.wb_valid && io.wb_prd == prs2_q[i]) rdy2_d[i] = 1'b1;
      if (io.flush_valid && valid_q[i] &&
          older(io.flush_robidx_flag, io.flush_robidx, flag_q[i], robidx_q[i]))
        valid_d[i] = 1'b0;
    end

    if (iss_fire) valid_d[win_idx] = 1'b0;

    // New entries capture a wakeup arriving in the same cycle.
    if (enq_fire) begin
      valid_d[free_idx]  = 1'b1;
      rdy1_d[free_idx]   = io.enq_src1_rdy | (io.wb_valid && io.wb_prd == io.enq_prs1);
      rdy2_d[free_idx]   = io.enq_src2_rdy | (io.wb_valid && io.wb_prd == io.enq_prs2);
      prd_d[free_idx]    = io.enq_prd;
      prs1_d[free_idx]   = io.enq_prs1;
      prs2_d[free_idx]   = io.enq_prs2;
      flag_d[free_idx]   = io.enq_robidx_flag;
      robidx_d[free_idx] = io.enq_robidx;
      uop_d[free_idx]    = io.enq_uop;
    end

    for (int i = 0; i < DEPTH; i++) count_d = count_d + CNT_W'(valid_d[i]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    prd_q    <= prd_d;
    prs1_q   <= prs1_d;
    prs2_q   <= prs2_d;
    flag_q   <= flag_d;
    robidx_q <= robidx_d;
    uop_q    <= uop_d;
  end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: expected issues are queued by the stimulus
// and checked by an independent monitor whenever an issue handshake occurs.
module tb_int_issue_queue;
  localparam int DEPTH = 8, PREG_W = 6, ROB_LOG = 6, UOP_W = 96;

  typedef struct packed {
    logic               flag;
    logic [ROB_LOG-1:0] idx;
    logic [PREG_W-1:0]  prd;
    logic [UOP_W-1:0]   uop;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int_issue_queue_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_LOG(ROB_LOG), .UOP_W(UOP_W)) bus ();

  int_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_LOG(ROB_LOG), .UOP_W(UOP_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [UOP_W-1:0] mk_uop(input logic [ROB_LOG-1:0] idx);
    return {10'h3A5, 80'h0, idx};
  endfunction

  function automatic logic [PREG_W-1:0] mk_prd(input logic [ROB_LOG-1:0] idx);
    return idx ^ 6'h15;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic f, input logic [ROB_LOG-1:0] idx);
    exp_t e;
    e.flag = f;
    e.idx  = idx;
    e.prd  = mk_prd(idx);
    e.uop  = mk_uop(idx);
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_enq(input logic f, input logic [ROB_LOG-1:0] idx,
                           input logic [PREG_W-1:0] p1, input logic r1);
    bus.enq_valid       = 1'b1;
    bus.enq_robidx_flag = f;
    bus.enq_robidx      = idx;
    bus.enq_prd         = mk_prd(idx);
    bus.enq_prs1        = p1;
    bus.enq_src1_rdy    = r1;
    bus.enq_prs2        = 6'd0;
    bus.enq_src2_rdy    = 1'b1;
    bus.enq_uop         = mk_uop(idx);
    #1 chk("enq_ready_offer", 128'(bus.enq_ready), 128'd1);
    cyc();
    bus.enq_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending issues expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.iss_valid && bus.iss_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got robidx %0h expected no issue", bus.iss_robidx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("iss_robidx", 128'({bus.iss_robidx_flag, bus.iss_robidx}), 128'({e.flag, e.idx}));
        chk("iss_prd", 128'(bus.iss_prd), 128'(e.prd));
        chk("iss_uop", 128'(bus.iss_uop), 128'(e.uop));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.enq_valid = 0; bus.enq_prd = 0; bus.enq_prs1 = 0; bus.enq_prs2 = 0;
    bus.enq_src1_rdy = 0; bus.enq_src2_rdy = 0; bus.enq_robidx_flag = 0;
    bus.enq_robidx = 0; bus.enq_uop = 0; bus.wb_valid = 0; bus.wb_prd = 0;
    bus.flush_valid = 0; bus.flush_robidx_flag = 0; bus.flush_robidx = 0;
    bus.iss_ready = 0;

    #1;
    chk("reset_count", 128'(bus.count), 128'd0);
    chk("reset_enq_ready", 128'(bus.enq_ready), 128'd1);
    chk("reset_iss_valid", 128'(bus.iss_valid), 128'd0);
    chk("reset_iss_uop", 128'(bus.iss_uop), 128'd0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // Oldest-first ordering among ready entries
    drive_enq(0, 6'd5, 6'd0, 1);
    drive_enq(0, 6'd3, 6'd0, 1);
    drive_enq(0, 6'd4, 6'd0, 1);
    chk("t1_count3", 128'(bus.count), 128'd3);
    push(0, 6'd3); push(0, 6'd4); push(0, 6'd5);
    bus.iss_ready = 1;
    drain();
    chk("t1_count0", 128'(bus.count), 128'd0);

    // Wakeup after enqueue
    drive_enq(0, 6'd10, 6'd7, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_wait_iss_valid", 128'(bus.iss_valid), 128'd0);
      cyc();
    end
    bus.wb_valid = 1; bus.wb_prd = 6'd7;
    #1 chk("t2_wb_cycle_iss_valid", 128'(bus.iss_valid), 128'd0);
    push(0, 6'd10);
    cyc();
    bus.wb_valid = 0;
    #1 chk("t2_woken_iss_valid", 128'(bus.iss_valid), 128'd1);
    drain();

    // Wakeup in the enqueue cycle
    bus.wb_valid = 1; bus.wb_prd = 6'd9;
    push(0, 6'd11);
    drive_enq(0, 6'd11, 6'd9, 0);
    bus.wb_valid = 0;
    #1 chk("t2b_iss_valid", 128'(bus.iss_valid), 128'd1);
    drain();

    // Wrap-flag age comparison
    bus.iss_ready = 0;
    drive_enq(1, 6'd2, 6'd0, 1);
    drive_enq(0, 6'd62, 6'd0, 1);
    push(0, 6'd62); push(1, 6'd2);
    bus.iss_ready = 1;
    drain();

    // Full queue
    bus.iss_ready = 0;
    for (int i = 0; i < DEPTH; i++) drive_enq(0, 6'(20 + i), 6'd8, 0);
    chk("t4_count_full", 128'(bus.count), 128'd8);
    chk("t4_enq_ready_full", 128'(bus.enq_ready), 128'd0);
    bus.enq_valid = 1; bus.enq_robidx = 6'd30; bus.enq_src1_rdy = 1;
    cyc();
    bus.enq_valid = 0;
    #1 chk("t4_ninth_rejected", 128'(bus.count), 128'd8);
    bus.wb_valid = 1; bus.wb_prd = 6'd8;
    cyc();
    bus.wb_valid = 0;
    for (int i = 0; i < DEPTH; i++) push(0, 6'(20 + i));
    bus.iss_ready = 1;
    cyc();
    chk("t4_enq_ready_after_issue", 128'(bus.enq_ready), 128'd1);
    chk("t4_count7", 128'(bus.count), 128'd7);
    drain();

    // Flush of younger entries
    bus.iss_ready = 0;
    for (int i = 1; i <= 4; i++) drive_enq(0, 6'(i), 6'd12, 0);
    bus.flush_valid = 1; bus.flush_robidx_flag = 0; bus.flush_robidx = 6'd2;
    bus.enq_valid = 1; bus.enq_robidx = 6'd50; bus.enq_src1_rdy = 1;
    bus.enq_prs1 = 6'd0; bus.enq_uop = mk_uop(6'd50);
    #1;
    chk("t5_flush_iss_valid", 128'(bus.iss_valid), 128'd0);
    chk("t5_flush_enq_ready", 128'(bus.enq_ready), 128'd0);
    cyc();
    bus.flush_valid = 0; bus.enq_valid = 0;
    #1 chk("t5_count_after_flush", 128'(bus.count), 128'd2);
    push(0, 6'd1); push(0, 6'd2);
    bus.wb_valid = 1; bus.wb_prd = 6'd12; bus.iss_ready = 1;
    cyc();
    bus.wb_valid = 0;
    drain();
    chk("t5_count0", 128'(bus.count), 128'd0);

    // Back-pressure holds the winner stable
    bus.iss_ready = 0;
    drive_enq(0, 6'd40, 6'd0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_hold_iss_valid", 128'(bus.iss_valid), 128'd1);
      chk("t6_hold_iss_robidx", 128'(bus.iss_robidx), 128'd40);
      chk("t6_hold_count", 128'(bus.count), 128'd1);
      cyc();
    end
    push(0, 6'd40);
    bus.iss_ready = 1;
    drain();
    chk("t6_count0", 128'(bus.count), 128'd0);

    // Asynchronous reset mid-operation
    bus.iss_ready = 0;
    drive_enq(0, 6'd33, 6'd0, 1);
    drive_enq(0, 6'd34, 6'd5, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("t7_reset_count", 128'(bus.count), 128'd0);
    chk("t7_reset_iss_valid", 128'(bus.iss_valid), 128'd0);
    chk("t7_reset_iss_robidx", 128'(bus.iss_robidx), 128'd0);
    chk("t7_reset_enq_ready", 128'(bus.enq_ready), 128'd1);
    cyc();
    reset_n = 1'b1;
    bus.iss_ready = 1;
    cyc(); cyc();
    chk("t7_post_reset_iss_valid", 128'(bus.iss_valid), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
